// File: rtl/mac_tx_arp_ip_arbiter_pkg.sv
// Shared definitions for the ARP/IP transmit arbiter: EtherType constants
// (also used by the receive-side demultiplexer) and the transmit FSM encoding.
package mac_tx_arp_ip_arbiter_pkg;

  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GRANT = 3'd2,
    ST_XFER  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_GAP   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/mac_tx_arp_ip_arbiter_rr.sv
// Two-requester grant selector: fixed ARP priority or round-robin, where the
// pointer favours the source that did not own the last frame.
module tx_rr_arbiter #(
  parameter bit P_FIXED_ARP = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic arp_req_i,
  input  logic ip_req_i,
  input  logic upd_i,
  input  logic upd_owner_arp_i,
  output logic arp_win_o,
  output logic ip_win_o
);

  logic favour_arp_q;
  logic favour_arp_d;

  // The update strobe is bypassed so a selection made in the same cycle
  // already sees the new pointer (matters when there is no idle gap).
  assign favour_arp_d = upd_i ? ~upd_owner_arp_i : favour_arp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) favour_arp_q <= 1'b0;
    else         favour_arp_q <= favour_arp_d;
  end

  assign arp_win_o = arp_req_i & (~ip_req_i | P_FIXED_ARP | favour_arp_d);
  assign ip_win_o  = ip_req_i & ~arp_win_o;

endmodule

// File: rtl/mac_tx_arp_ip_arbiter.sv
// Transmit-side ARP/IP arbiter: picks one source, handshakes with MAC_tx,
// streams the owner's bytes with EtherType/length, polices length, adds a gap.
module mac_tx_arp_ip_arbiter
  import mac_tx_arp_ip_arbiter_pkg::*;
#(
  parameter bit          P_ARP_PRIORITY = 1'b1,
  parameter int unsigned P_GAP_CYCLES   = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_arp_req,
  input  logic [15:0] i_arp_len,
  output logic        o_arp_grant,
  input  logic [7:0]  i_arp_data,
  input  logic        i_arp_last,
  input  logic        i_arp_valid,
  input  logic        i_ip_req,
  input  logic [15:0] i_ip_len,
  output logic        o_ip_grant,
  input  logic [7:0]  i_ip_data,
  input  logic        i_ip_last,
  input  logic        i_ip_valid,
  output logic        o_mac_req,
  input  logic        i_mac_ready,
  output logic [15:0] o_send_type,
  output logic [15:0] o_send_len,
  output logic [7:0]  o_send_data,
  output logic        o_send_last,
  output logic        o_send_valid,
  output logic        o_len_error,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state
);

  localparam int unsigned GAP_LAST_I = (P_GAP_CYCLES == 0) ? 0 : P_GAP_CYCLES - 1;
  localparam logic [15:0] GAP_LAST   = 16'(GAP_LAST_I);
  localparam tx_state_e   END_STATE  = (P_GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  tx_state_e   state_q;
  logic        owner_arp_q;
  logic [15:0] send_type_q, send_len_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] gap_q;
  logic        mac_req_q, arp_grant_q, ip_grant_q;
  logic [7:0]  send_data_q;
  logic        send_last_q, send_valid_q, len_error_q;
  logic        rr_upd_q;

  logic        arb_arp, arb_ip;
  logic        own_valid, own_last;
  logic [7:0]  own_data;
  logic        len_checked, len_hit, frame_end;

  tx_rr_arbiter #(
    .P_FIXED_ARP(P_ARP_PRIORITY)
  ) u_rr (
    .clk_i          (i_clk),
    .rst_ni         (i_rst),
    .arp_req_i      (i_arp_req),
    .ip_req_i       (i_ip_req),
    .upd_i          (rr_upd_q),
    .upd_owner_arp_i(owner_arp_q),
    .arp_win_o      (arb_arp),
    .ip_win_o       (arb_ip)
  );

  assign own_valid   = owner_arp_q ? i_arp_valid : i_ip_valid;
  assign own_last    = owner_arp_q ? i_arp_last  : i_ip_last;
  assign own_data    = owner_arp_q ? i_arp_data  : i_ip_data;
  assign cnt_d       = cnt_q + 16'd1;
  assign len_checked = (send_len_q != 16'd0);
  assign len_hit     = len_checked && (cnt_d == send_len_q);
  // The counter never passes len, so any owner last in XFER/DRAIN ends the frame.
  assign frame_end   = ((state_q == ST_XFER) || (state_q == ST_DRAIN)) && own_valid && own_last;

  // MAC handshake: o_mac_req is held until a cycle with i_mac_ready high;
  // that cycle completes the request and o_mac_req is low from the next cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      owner_arp_q  <= 1'b0;
      send_type_q  <= 16'd0;
      send_len_q   <= 16'd0;
      cnt_q        <= 16'd0;
      gap_q        <= 16'd0;
      mac_req_q    <= 1'b0;
      arp_grant_q  <= 1'b0;
      ip_grant_q   <= 1'b0;
      send_data_q  <= 8'd0;
      send_last_q  <= 1'b0;
      send_valid_q <= 1'b0;
      len_error_q  <= 1'b0;
      rr_upd_q     <= 1'b0;
    end else begin
      arp_grant_q  <= 1'b0;
      ip_grant_q   <= 1'b0;
      send_valid_q <= 1'b0;
      send_last_q  <= 1'b0;
      len_error_q  <= 1'b0;
      rr_upd_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_arp || arb_ip) begin
            owner_arp_q <= arb_arp;
            send_type_q <= arb_arp ? ETH_TYPE_ARP : ETH_TYPE_IP;
            send_len_q  <= arb_arp ? i_arp_len : i_ip_len;
            mac_req_q   <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_mac_ready) begin
            mac_req_q   <= 1'b0;
            arp_grant_q <= owner_arp_q;
            ip_grant_q  <= ~owner_arp_q;
            cnt_q       <= 16'd0;
            state_q     <= ST_GRANT;
          end
        end
        ST_GRANT: state_q <= ST_XFER;
        ST_XFER: begin
          if (own_valid) begin
            cnt_q        <= cnt_d;
            send_valid_q <= 1'b1;
            send_data_q  <= own_data;
            if (len_hit) begin
              send_last_q <= 1'b1;
              len_error_q <= ~own_last;
              if (!own_last) state_q <= ST_DRAIN;
            end else if (own_last) begin
              send_last_q <= 1'b1;
              len_error_q <= len_checked;
            end
          end
        end
        ST_DRAIN: ;
        ST_GAP: begin
          if (gap_q == GAP_LAST) state_q <= ST_IDLE;
          else                   gap_q   <= gap_q + 16'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (frame_end) begin
        state_q  <= END_STATE;
        gap_q    <= 16'd0;
        rr_upd_q <= 1'b1;
      end
    end
  end

  assign o_arp_grant  = arp_grant_q;
  assign o_ip_grant   = ip_grant_q;
  assign o_mac_req    = mac_req_q;
  assign o_send_type  = send_type_q;
  assign o_send_len   = send_len_q;
  assign o_send_data  = send_data_q;
  assign o_send_last  = send_last_q;
  assign o_send_valid = send_valid_q;
  assign o_len_error  = len_error_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_mac_tx_arp_ip_arbiter.sv
// Bench for mac_tx_arp_ip_arbiter: instance 0 uses ARP priority, instance 1
// round-robin; a frame table plus contention and mid-frame reset sequences.
module tb_mac_tx_arp_ip_arbiter;

  logic        clk;
  logic        rst_n;
  logic        arp_req[2], arp_grant[2], arp_last[2], arp_valid[2];
  logic [15:0] arp_len[2];
  logic [7:0]  arp_data[2];
  logic        ip_req[2], ip_grant[2], ip_last[2], ip_valid[2];
  logic [15:0] ip_len[2];
  logic [7:0]  ip_data[2];
  logic        mac_req[2], mac_ready[2];
  logic [15:0] send_type[2], send_len[2];
  logic [7:0]  send_data[2];
  logic        send_last[2], send_valid[2], len_error[2], busy[2];
  logic [2:0]  dbg_state[2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mon     = 0;
  logic [9:0]  exp_q[$];

  typedef struct {
    bit          arp;
    logic [15:0] len;
    int          n;
    int          rdy;
    int          gap_at;
    int          exp_cnt;
    bit          exp_err;
    logic [15:0] exp_type;
  } vec_t;
  vec_t vecs[6];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  mac_tx_arp_ip_arbiter #(.P_ARP_PRIORITY(1'b1), .P_GAP_CYCLES(12)) u_dut0 (
    .i_clk(clk), .i_rst(rst_n),
    .i_arp_req(arp_req[0]), .i_arp_len(arp_len[0]), .o_arp_grant(arp_grant[0]),
    .i_arp_data(arp_data[0]), .i_arp_last(arp_last[0]), .i_arp_valid(arp_valid[0]),
    .i_ip_req(ip_req[0]), .i_ip_len(ip_len[0]), .o_ip_grant(ip_grant[0]),
    .i_ip_data(ip_data[0]), .i_ip_last(ip_last[0]), .i_ip_valid(ip_valid[0]),
    .o_mac_req(mac_req[0]), .i_mac_ready(mac_ready[0]),
    .o_send_type(send_type[0]), .o_send_len(send_len[0]), .o_send_data(send_data[0]),
    .o_send_last(send_last[0]), .o_send_valid(send_valid[0]), .o_len_error(len_error[0]),
    .o_busy(busy[0]), .o_dbg_state(dbg_state[0])
  );

  mac_tx_arp_ip_arbiter #(.P_ARP_PRIORITY(1'b0), .P_GAP_CYCLES(12)) u_dut1 (
    .i_clk(clk), .i_rst(rst_n),
    .i_arp_req(arp_req[1]), .i_arp_len(arp_len[1]), .o_arp_grant(arp_grant[1]),
    .i_arp_data(arp_data[1]), .i_arp_last(arp_last[1]), .i_arp_valid(arp_valid[1]),
    .i_ip_req(ip_req[1]), .i_ip_len(ip_len[1]), .o_ip_grant(ip_grant[1]),
    .i_ip_data(ip_data[1]), .i_ip_last(ip_last[1]), .i_ip_valid(ip_valid[1]),
    .o_mac_req(mac_req[1]), .i_mac_ready(mac_ready[1]),
    .o_send_type(send_type[1]), .o_send_len(send_len[1]), .o_send_data(send_data[1]),
    .o_send_last(send_last[1]), .o_send_valid(send_valid[1]), .o_len_error(len_error[1]),
    .o_busy(busy[1]), .o_dbg_state(dbg_state[1])
  );

  function automatic logic [7:0] pat(input bit arp, input int i);
    logic [7:0] b;
    b = 8'(i);
    return (arp ? 8'hA0 : 8'h10) + b;
  endfunction

  function automatic logic [46:0] outs(input int d);
    return {arp_grant[d], ip_grant[d], mac_req[d], send_type[d], send_len[d], send_data[d],
            send_last[d], send_valid[d], len_error[d], busy[d]};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  // scoreboard: each emitted byte is compared with the head of exp_q
  task automatic monitor();
    logic [9:0] g, e;
    g = {len_error[mon], send_last[mon], send_data[mon]};
    if (send_valid[mon]) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_byte: got err/last/data %h, required no byte", g);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_fail++;
          $display("FAIL out_byte: got err/last/data %h, required %h", g, e);
        end
      end
    end else if (len_error[mon]) begin
      n_tests++;
      n_fail++;
      $display("FAIL stray_len_error: got 1, required 0 without valid");
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input int d, input bit arp, input logic v, input logic l, input logic [7:0] b);
    if (arp) begin
      arp_valid[d] = v; arp_last[d] = l; arp_data[d] = b;
    end else begin
      ip_valid[d] = v; ip_last[d] = l; ip_data[d] = b;
    end
  endtask

  task automatic handshake(input int d, input bit arp, input logic [15:0] len, input int rdy,
                           input logic [15:0] exp_type);
    int k;
    if (arp) begin arp_req[d] = 1'b1; arp_len[d] = len; end
    else     begin ip_req[d]  = 1'b1; ip_len[d]  = len; end
    k = 0;
    while (!mac_req[d] && k < 50) begin tick(); k++; end
    check("mac_req_rise", 64'(k < 50), 64'd1);
    for (int i = 0; i < rdy; i++) tick();
    check("mac_req_held", 64'(mac_req[d]), 64'd1);
    mac_ready[d] = 1'b1;
    tick();
    mac_ready[d] = 1'b0;
    check("own_grant", 64'(arp ? arp_grant[d] : ip_grant[d]), 64'd1);
    check("other_grant", 64'(arp ? ip_grant[d] : arp_grant[d]), 64'd0);
    check("mac_req_drop", 64'(mac_req[d]), 64'd0);
    check("send_type", 64'(send_type[d]), 64'(exp_type));
    check("send_len", 64'(send_len[d]), 64'(len));
    if (arp) arp_req[d] = 1'b0; else ip_req[d] = 1'b0;
    tick();
    check("grant_pulse", 64'(arp ? arp_grant[d] : ip_grant[d]), 64'd0);
  endtask

  // the non-owner source chatters with junk bytes that must be ignored
  task automatic stream(input int d, input bit arp, input int n, input int gap_at);
    for (int i = 1; i <= n; i++) begin
      if (i == gap_at) begin
        drive(d, arp, 1'b0, 1'b0, 8'h00);
        tick();
      end
      drive(d, arp, 1'b1, (i == n), pat(arp, i));
      drive(d, !arp, 1'b1, 1'(i), 8'hEE);
      tick();
    end
    drive(d, arp, 1'b0, 1'b0, 8'h00);
    drive(d, !arp, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int d);
    int k;
    k = 0;
    while (busy[d] && k < 100) begin tick(); k++; end
    check("gap_cycles", 64'(k), 64'd12);
    check("bytes_missing", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_frame(input int d, input bit arp, input logic [15:0] len, input int n,
                           input int rdy, input int gap_at, input int exp_cnt, input bit exp_err,
                           input logic [15:0] exp_type);
    mon = d;
    for (int i = 1; i <= exp_cnt; i++)
      exp_q.push_back({(exp_err && i == exp_cnt), (i == exp_cnt), pat(arp, i)});
    handshake(d, arp, len, rdy, exp_type);
    stream(d, arp, n, gap_at);
    check("type_hold", 64'(send_type[d]), 64'(exp_type));
    check("len_hold", 64'(send_len[d]), 64'(len));
    wait_idle(d);
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'd5,  5,  3, 0, 5,  1'b0, 16'h0800};
    vecs[1] = '{1'b0, 16'd4,  6,  0, 0, 4,  1'b1, 16'h0800};
    vecs[2] = '{1'b1, 16'd28, 20, 1, 3, 20, 1'b1, 16'h0806};
    vecs[3] = '{1'b1, 16'd0,  7,  2, 5, 7,  1'b0, 16'h0806};
    vecs[4] = '{1'b0, 16'd1,  1,  0, 0, 1,  1'b0, 16'h0800};
    vecs[5] = '{1'b1, 16'd3,  3,  4, 2, 3,  1'b0, 16'h0806};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      arp_req[d] = 1'b0; arp_len[d] = 16'd0; ip_req[d] = 1'b0; ip_len[d] = 16'd0;
      mac_ready[d] = 1'b0;
      drive(d, 1'b1, 1'b0, 1'b0, 8'h00);
      drive(d, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_outs", 64'(outs(d)), 64'd0);
      check("reset_state", 64'(dbg_state[d]), 64'd0);
    end
    rst_n = 1'b1;
    tick();

    // table of single frames on the ARP-priority instance
    for (int v = 0; v < 6; v++)
      run_frame(0, vecs[v].arp, vecs[v].len, vecs[v].n, vecs[v].rdy, vecs[v].gap_at,
                vecs[v].exp_cnt, vecs[v].exp_err, vecs[v].exp_type);

    // simultaneous requests, fixed priority: ARP first, IP after the gap
    ip_req[0] = 1'b1;
    ip_len[0] = 16'd2;
    run_frame(0, 1'b1, 16'd2, 2, 1, 0, 2, 1'b0, 16'h0806);
    run_frame(0, 1'b0, 16'd2, 2, 0, 0, 2, 1'b0, 16'h0800);

    // round-robin instance: IP owns first, then contention goes to ARP, then IP
    run_frame(1, 1'b0, 16'd3, 3, 0, 0, 3, 1'b0, 16'h0800);
    ip_req[1] = 1'b1;
    ip_len[1] = 16'd2;
    run_frame(1, 1'b1, 16'd2, 2, 1, 0, 2, 1'b0, 16'h0806);
    arp_req[1] = 1'b1;
    arp_len[1] = 16'd2;
    run_frame(1, 1'b0, 16'd2, 2, 2, 0, 2, 1'b0, 16'h0800);
    run_frame(1, 1'b1, 16'd2, 2, 0, 0, 2, 1'b0, 16'h0806);

    // reset during byte 3 of an IP frame, request held through reset
    mon = 0;
    exp_q.push_back({1'b0, 1'b0, pat(1'b0, 1)});
    exp_q.push_back({1'b0, 1'b0, pat(1'b0, 2)});
    handshake(0, 1'b0, 16'd8, 0, 16'h0800);
    ip_req[0] = 1'b1;
    ip_len[0] = 16'd3;
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1'b0, 1'b1, 1'b0, pat(1'b0, i));
      tick();
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("byte3_valid_before_reset", 64'(send_valid[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outs", 64'(outs(0)), 64'd0);
    check("mid_reset_state", 64'(dbg_state[0]), 64'd0);
    tick();
    tick();
    check("pre_reset_bytes", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b1;
    run_frame(0, 1'b0, 16'd3, 3, 1, 0, 3, 1'b0, 16'h0800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tx_arp_ip_arbiter.md
Name: mac_tx_arp_ip_arbiter

Overview:
- Transmit-side counterpart of the receive ARP/IP demultiplexer.
- Arbitrates between the ARP and IP frame sources, then drives one frame at a time into MAC_tx through its request/ready handshake and byte stream.
- Inserts the EtherType, forwards the payload length, enforces byte count against the declared length, and inserts an inter-frame idle gap.

Parameters:
P_ARP_PRIORITY, 1, 1 = ARP wins every contention; 0 = round-robin (last loser wins next).
P_GAP_CYCLES, 12, idle cycles after each o_send_last before the next arbitration (0 allowed).

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_arp_req  in  1  ARP source has a frame pending (level, held until granted)
i_arp_len  in  16  ARP payload byte count, stable while i_arp_req
o_arp_grant  out  1  one-cycle pulse: ARP may stream
i_arp_data  in  8  ARP payload byte
i_arp_last  in  1  final ARP byte
i_arp_valid  in  1  ARP byte valid
i_ip_req  in  1  IP frame pending
i_ip_len  in  16  IP payload byte count
o_ip_grant  out  1  one-cycle pulse: IP may stream
i_ip_data  in  8  IP payload byte
i_ip_last  in  1  final IP byte
i_ip_valid  in  1  IP byte valid
o_mac_req  out  1  to MAC_tx i_udp_valid
i_mac_ready  in  1  from MAC_tx o_udp_ready
o_send_type  out  16  EtherType: 16'h0806 ARP, 16'h0800 IP
o_send_len  out  16  latched length of the granted source
o_send_data  out  8  payload byte
o_send_last  out  1  final byte
o_send_valid  out  1  byte valid
o_len_error  out  1  one-cycle pulse on length mismatch
o_busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - All outputs 0; o_send_type = 0; o_send_len = 0.
  - State = IDLE; round-robin pointer = IP-favoured; byte counter = 0.
- IDLE:
  - If either req is high, pick the winner (priority rule above).
  - Latch the owner, o_send_type and o_send_len (the owner's i_*_len), then go to REQ.
  - Requests arriving in any other state wait; they are never dropped while held.
- REQ:
  - o_mac_req = 1 until a cycle with i_mac_ready = 1.
  - In that cycle go to GRANT, and o_mac_req drops the next cycle.
- GRANT:
  - Owner's grant pulses high for exactly one cycle; go to XFER.
  - The owner deasserts its req after the grant; a req still high at the next IDLE is treated as a new frame.
- XFER, data path:
  - Owner's data/last/valid are registered to o_send_* with 1-cycle latency.
  - The non-owner's stream inputs are ignored.
- XFER, byte counter:
  - Counter increments on each accepted owner byte, 16-bit.
  - Length check applies only if the latched len != 0. Len 0 means unchecked: pass through until owner last.
- XFER, last before len (counter+1 < len):
  - Forward last normally.
  - o_len_error pulses together with that o_send_last.
- XFER, count reaches len without last:
  - That byte is emitted with o_send_last = 1 forced, and o_len_error pulses.
  - State goes to DRAIN.
- XFER, normal end: owner last with counter+1 == len (or unchecked) → GAP after o_send_last is emitted.
- DRAIN:
  - Discard owner bytes; o_send_valid = 0.
  - On owner last, go to GAP.
- GAP:
  - Count P_GAP_CYCLES cycles, then go to IDLE. P_GAP_CYCLES = 0 goes straight to IDLE.
  - Round-robin pointer updates at GAP entry.
- Simultaneous req in IDLE: P_ARP_PRIORITY = 1 → ARP. Otherwise the source other than the previous owner wins.
- o_send_type and o_send_len are held constant from REQ through the end of GAP.
- Reset asserted mid-frame: all outputs clear asynchronously. No trailing last is generated; MAC_tx is reset by the same signal.
- Upstream gaps in valid during XFER are allowed; there is no timeout.

Decomposition:
- Shared package: EtherType constants (ETH_TYPE_IP = 16'h0800, ETH_TYPE_ARP = 16'h0806) and the state encoding (IDLE, REQ, GRANT, XFER, DRAIN, GAP).
- The RX mux uses the same EtherType constants.
- One sub-module is natural: tx_rr_arbiter, a 2-requester fixed/round-robin grant selector with a pointer-update strobe.

Test Plan:
- IP only, len = 5, 5 bytes with last on byte 5; i_mac_ready 3 cycles after o_mac_req
  → o_ip_grant one pulse; o_send_type = 16'h0800, o_send_len = 5; 5 valid bytes, last on 5th; no o_len_error; o_busy low 12 cycles after last.
- ARP and IP req in the same cycle, P_ARP_PRIORITY = 1
  → ARP frame first (type 16'h0806), then IP after the 12-cycle gap.
- Repeat with P_ARP_PRIORITY = 0, IP previous owner
  → ARP first; next contention → IP first.
- IP len = 4 but 6 bytes sent → o_send_last forced on 4th byte with o_len_error pulse; bytes 5–6 absent; GAP entered after the upstream last.
- ARP len = 28, last on byte 20 → 20 bytes out, last on 20th, o_len_error pulse with it.
- Assert reset during XFER byte 3 → all outputs 0 immediately; after release with req still high, a fresh REQ/GRANT sequence starts normally.
